// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request side and a valid/ready
// result side. Logic, shift and compare operations finish in one cycle.
// MUL/MULHU/DIV/DIVU/REM/REMU iterate one bit per cycle for XLEN cycles.
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : request handshake; in_ready is high only when idle
//   alu_ctrl             : 4-bit operation code
//   alu_in_1 / alu_in_2  : operands A / B (captured on acceptance)
//   out_valid / out_ready: result handshake; the result is held until taken
//   alu_out, zero        : registered result; zero flags SUB == 0
module alu_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_in_1,
  input  logic [XLEN-1:0] alu_in_2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic            zero
);

  localparam int unsigned SHW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010, OP_XOR  = 4'b0011,
    OP_SRL  = 4'b0100, OP_MUL  = 4'b0101, OP_SUB  = 4'b0110, OP_MULH = 4'b0111,
    OP_SLTU = 4'b1000, OP_SLL  = 4'b1001, OP_SRA  = 4'b1010, OP_SLT  = 4'b1011
  } op_t;

  state_t              state_q, state_d;
  logic [SHW-1:0]      cnt_q, cnt_d;
  logic [3:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     alu_out_q, alu_out_d;
  logic                zero_q, zero_d;

  logic [SHW-1:0]      shamt;
  logic [XLEN-1:0]     quick_res;
  logic                multi_op;
  logic [XLEN-1:0]     a_load;

  // Single-cycle results straight from the request inputs.
  assign shamt    = alu_in_2[SHW-1:0];
  assign multi_op = (alu_ctrl == OP_MUL) || (alu_ctrl == OP_MULH) || (alu_ctrl[3:2] == 2'b11);

  always_comb begin
    quick_res = '0;
    case (alu_ctrl)
      OP_AND:  quick_res = alu_in_1 & alu_in_2;
      OP_OR:   quick_res = alu_in_1 | alu_in_2;
      OP_ADD:  quick_res = alu_in_1 + alu_in_2;
      OP_XOR:  quick_res = alu_in_1 ^ alu_in_2;
      OP_SRL:  quick_res = alu_in_1 >> shamt;
      OP_SUB:  quick_res = alu_in_1 - alu_in_2;
      OP_SLTU: quick_res[0] = (alu_in_1 < alu_in_2);
      OP_SLL:  quick_res = alu_in_1 << shamt;
      OP_SRA:  quick_res = XLEN'($signed(alu_in_1) >>> shamt);
      OP_SLT:  quick_res[0] = ($signed(alu_in_1) < $signed(alu_in_2));
      default: quick_res = '0;
    endcase
  end

  // Signed divides iterate on magnitudes; the dividend magnitude is loaded
  // into the low half of the accumulator at acceptance.
  assign a_load = (alu_ctrl[3:2] == 2'b11 && alu_ctrl[1] && alu_in_1[XLEN-1])
                  ? (-alu_in_1) : alu_in_1;

  logic                is_div;
  logic [XLEN-1:0]     b_mag;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       div_shift;
  logic                div_ge;
  logic [XLEN-1:0]     div_sub;
  logic [2*XLEN-1:0]   div_next;
  logic [XLEN-1:0]     q_fix, r_fix;
  logic [XLEN-1:0]     calc_res;

  assign is_div = (op_q[3:2] == 2'b11);
  assign b_mag  = (op_q[1] && b_q[XLEN-1]) ? (-b_q) : b_q;

  // Shift-add multiply: acc = {partial high, multiplier bits still unused}.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide: acc = {partial remainder, dividend/quotient bits}.
  assign div_shift = acc_q[2*XLEN-1:XLEN-1];
  assign div_ge    = (div_shift >= {1'b0, b_mag});
  assign div_sub   = div_shift[XLEN-1:0] - b_mag;
  assign div_next  = div_ge ? {div_sub, acc_q[XLEN-2:0], 1'b1}
                            : {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

  // Divide-by-zero is forced explicitly; most-negative / -1 falls out of the
  // magnitude arithmetic (2^(XLEN-1) negated wraps to itself, remainder 0).
  always_comb begin
    q_fix = div_next[XLEN-1:0];
    r_fix = div_next[2*XLEN-1:XLEN];
    if (b_q == '0) begin
      q_fix = '1;
      r_fix = a_q;
    end else if (op_q[1]) begin
      if (a_q[XLEN-1] ^ b_q[XLEN-1]) q_fix = -div_next[XLEN-1:0];
      if (a_q[XLEN-1])               r_fix = -div_next[2*XLEN-1:XLEN];
    end
    if (is_div)       calc_res = op_q[0] ? r_fix : q_fix;
    else if (op_q[1]) calc_res = mul_next[2*XLEN-1:XLEN];
    else              calc_res = mul_next[XLEN-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    alu_out_d = alu_out_q;
    zero_d    = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d = alu_ctrl;
          a_d  = alu_in_1;
          b_d  = alu_in_2;
          if (multi_op) begin
            state_d = S_CALC;
            cnt_d   = '0;
            acc_d   = {{XLEN{1'b0}}, a_load};
          end else begin
            state_d   = S_DONE;
            alu_out_d = quick_res;
            zero_d    = (alu_ctrl == OP_SUB) && (quick_res == '0);
          end
        end
      end
      S_CALC: begin
        acc_d = is_div ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(XLEN - 1)) begin
          state_d   = S_DONE;
          cnt_d     = '0;
          alu_out_d = calc_res;
          zero_d    = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      alu_out_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      alu_out_q <= alu_out_d;
      zero_q    <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign alu_out   = alu_out_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_in_1;
  logic [31:0] alu_in_2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_out;
  logic        zero;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  alu_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .alu_in_1  (alu_in_1),
    .alu_in_2  (alu_in_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // Issue one request, scramble inputs while busy, check latency/result/zero,
  // then check the result is consumed and alu_out retained.
  task automatic run_vec(input string tag, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic ez,
                         input int exp_lat);
    int lat;
    check({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    alu_ctrl = c; alu_in_1 = a; alu_in_2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (!out_valid && lat < 200) begin
      alu_ctrl = 4'($urandom); alu_in_1 = $urandom; alu_in_2 = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, alu_out, er);
    check({tag, "_zero"}, {31'b0, zero}, {31'b0, ez});
    @(posedge clk); #1;
    check({tag, "_vld_low"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_keep"}, alu_out, er);
    in_valid = 1'b0;
  endtask

  initial begin
    int highs;
    rst_n = 1'b1; in_valid = 1'b0; alu_ctrl = '0; alu_in_1 = '0; alu_in_2 = '0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_alu_out",   alu_out,            32'd0);
    check("rst_zero",      {31'b0, zero},      32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Stall in DONE with a zero-flag result, new requests pending.
    out_ready = 1'b0;
    alu_ctrl = 4'b0110; alu_in_1 = 32'd9; alu_in_2 = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    check("stall_vld0", {31'b0, out_valid}, 32'd1);
    check("stall_res0", alu_out, 32'd0);
    check("stall_z0",   {31'b0, zero}, 32'd1);
    alu_ctrl = 4'b0010; alu_in_1 = 32'd1; alu_in_2 = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_vld", {31'b0, out_valid}, 32'd1);
      check("stall_res", alu_out, 32'd0);
      check("stall_z",   {31'b0, zero}, 32'd1);
      check("stall_rdy", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rel_vld", {31'b0, out_valid}, 32'd0);
    check("rel_rdy", {31'b0, in_ready}, 32'd1);
    check("rel_res", alu_out, 32'd0);
    @(posedge clk); #1;
    check("rel_idle", {31'b0, out_valid}, 32'd0);

    run_vec("add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1);
    run_vec("sub_eq",   4'b0110, 32'd5,        32'd5,        32'h00000000, 1'b1, 1);
    run_vec("sub_neg",  4'b0110, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1);
    run_vec("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1);
    run_vec("slt",      4'b1011, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1);
    run_vec("sltu",     4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1);
    run_vec("sra",      4'b1010, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1);
    run_vec("srl",      4'b0100, 32'h80000000, 32'h00000021, 32'h40000000, 1'b0, 1);
    run_vec("sll",      4'b1001, 32'h00000001, 32'h0000003F, 32'h80000000, 1'b0, 1);
    run_vec("and",      4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1);
    run_vec("or",       4'b0001, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1);
    run_vec("xor",      4'b0011, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1);
    run_vec("mul_m1",   4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33);
    run_vec("mulhu_m1", 4'b0111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
    run_vec("mul",      4'b0101, 32'h12345678, 32'h00000010, 32'h23456780, 1'b0, 33);
    run_vec("mulhu",    4'b0111, 32'h12345678, 32'h00000010, 32'h00000001, 1'b0, 33);
    run_vec("div_n7_2", 4'b1110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 33);
    run_vec("rem_n7_2", 4'b1111, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 33);
    run_vec("div_7_n2", 4'b1110, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33);
    run_vec("rem_7_n2", 4'b1111, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
    run_vec("divu_z",   4'b1100, 32'h00000009, 32'h00000000, 32'hFFFFFFFF, 1'b0, 33);
    run_vec("remu_z",   4'b1101, 32'h00000009, 32'h00000000, 32'h00000009, 1'b0, 33);
    run_vec("div_z",    4'b1110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1'b0, 33);
    run_vec("rem_z",    4'b1111, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1'b0, 33);
    run_vec("div_ovf",  4'b1110, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33);
    run_vec("rem_ovf",  4'b1111, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 33);
    run_vec("divu",     4'b1100, 32'd100,      32'd7,        32'h0000000E, 1'b0, 33);
    run_vec("remu",     4'b1101, 32'd100,      32'd7,        32'h00000002, 1'b0, 33);

    // Reset ten cycles into a DIV: asynchronous clear, result never shown.
    alu_ctrl = 4'b1110; alu_in_1 = 32'd100; alu_in_2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_rdy", {31'b0, in_ready},  32'd1);
    check("mid_rst_vld", {31'b0, out_valid}, 32'd0);
    check("mid_rst_res", alu_out,            32'd0);
    check("mid_rst_z",   {31'b0, zero},      32'd0);
    @(posedge clk); @(posedge clk); #1;
    check("mid_rst_hold", {31'b0, out_valid}, 32'd0);
    rst_n = 1'b1;
    run_vec("rst_add", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) highs++;
    end
    check("no_stale_result", 32'(highs), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (>=8, power of two).
REQ-002 SHALL have derived localparam SHW = log2(XLEN), the shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port alu_ctrl  input  4  operation code.
REQ-008 SHALL have port alu_in_1  input  XLEN  operand A.
REQ-009 SHALL have port alu_in_2  input  XLEN  operand B.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port alu_out  output  XLEN  registered result.
REQ-013 SHALL have port zero  output  1  branch-equal flag, valid with out_valid.

Function
REQ-014 SHALL decode alu_ctrl: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SRL, 0101 MUL (low XLEN), 0110 SUB, 0111 MULHU (high XLEN, unsigned), 1000 SLTU, 1001 SLL, 1010 SRA, 1011 SLT (signed), 1100 DIVU, 1101 REMU, 1110 DIV, 1111 REM.
REQ-015 SHALL use alu_in_2[SHW-1:0] as shift amount; upper bits ignored.
REQ-016 SHALL perform ADD/SUB/MUL modulo 2^XLEN, no overflow flag.
REQ-017 SHALL zero-extend SLT/SLTU result (1 or 0) to XLEN.
REQ-018 SHALL set zero = 1 only for SUB with result 0, else 0.
REQ-019 SHALL run FSM states IDLE, CALC, DONE; in_ready = 1 only in IDLE.
REQ-020 SHALL capture opcode/operands on the edge where in_valid && in_ready (acceptance edge).
REQ-021 SHALL, for single-cycle ops (all except 0101, 0111, 11xx), go IDLE->DONE on acceptance, out_valid high the next cycle (latency 1).
REQ-022 SHALL, for MUL/MULHU/DIV*/REM*, go IDLE->CALC, iterate one bit per cycle (shift-add multiply, restoring divide) with an iteration counter, and enter DONE exactly XLEN cycles after acceptance edge (out_valid latency XLEN+1).
REQ-023 SHALL compute signed DIV/REM on magnitudes, quotient negated if operand signs differ, remainder takes sign of dividend.
REQ-024 SHALL, on divide by zero, return quotient all-ones (DIV, DIVU) and remainder = alu_in_1 (REM, REMU), same latency.
REQ-025 SHALL, on DIV of most-negative by -1, return most-negative; REM returns 0.
REQ-026 SHALL hold alu_out, zero and out_valid stable in DONE until out_ready = 1; DONE->IDLE on that edge, out_valid low next cycle.
REQ-027 SHALL ignore in_valid and input changes while in CALC or DONE; captured operands SHALL not change.
REQ-028 SHALL keep alu_out at last result after out_valid falls.

Reset
REQ-029 SHALL, while rst_n = 0, force state IDLE, counter 0, alu_out 0, zero 0, out_valid 0, in_ready 1 immediately, independent of clk.
REQ-030 SHALL abort any CALC/DONE operation on reset mid-operation; no result from it is ever presented.
REQ-031 SHALL accept a new request on the first rising edge after rst_n deasserts.

Verification
REQ-032 ADD 0x7FFFFFFF + 0x00000001, out_ready=1 -> out_valid 1 cycle later, alu_out 0x80000000, zero 0; SUB 5-5 -> alu_out 0, zero 1.
REQ-033 SLT 0xFFFFFFFF vs 1 -> 1; SLTU same -> 0; SRA 0x80000000 by 0x24 (amount 4) -> 0xF8000000.
REQ-034 MUL 0xFFFFFFFF x 0xFFFFFFFF -> out_valid at cycle 33 after acceptance, alu_out 0x00000001; MULHU same -> 0xFFFFFFFE.
REQ-035 DIV -7 / 2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIVU 9 / 0 -> 0xFFFFFFFF, REMU -> 9; DIV 0x80000000 / -1 -> 0x80000000.
REQ-036 out_ready held 0 for 5 cycles in DONE -> alu_out, zero, out_valid stable, in_ready 0, new in_valid ignored; release -> IDLE next cycle.
REQ-037 rst_n pulsed low at cycle 10 of a DIV -> outputs reset asynchronously, no out_valid; next ADD 2+3 -> 5 with latency 1.
